// File: rtl/core_end_monitor_pkg.sv
// Shared types and constants for the end-of-test monitor.
package core_mon_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        DRAIN     = 3'd2,
        DONE_PASS = 3'd3,
        DONE_FAIL = 3'd4
    } mon_state_e;

    typedef enum logic [1:0] {
        FAIL_NONE    = 2'd0,
        FAIL_HANG    = 2'd1,
        FAIL_TIMEOUT = 2'd2
    } fail_code_e;

    function automatic logic is_terminal(input mon_state_e st);
        return (st == DONE_PASS) || (st == DONE_FAIL);
    endfunction

endpackage

// File: rtl/core_end_monitor_if.sv
// Retirement stream in, status and statistics out.
interface core_end_monitor_if;
    import core_mon_pkg::*;

    logic             retire_valid;
    logic [31:0]      retire_pc;
    logic             done;
    logic             pass;
    logic [1:0]       fail_code;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retire_count;

    modport master (
        output retire_valid, retire_pc,
        input  done, pass, fail_code, cycle_count, retire_count
    );

    modport slave (
        input  retire_valid, retire_pc,
        output done, pass, fail_code, cycle_count, retire_count
    );
endinterface

// File: rtl/core_end_monitor_sat_counter.sv
// Up-counter that sticks at all-ones; hold beats clear beats increment.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             hold,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;

    // Count register with saturation at the maximum value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (hold) begin
            count_r <= count_r;
        end else if (clr) begin
            count_r <= {WIDTH{1'b0}};
        end else if (inc && (count_r != {WIDTH{1'b1}})) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/core_end_monitor.sv
// Watches the retirement stream for program end, drains the pipe, and reports
// pass / hang / timeout with frozen cycle and retire statistics.
module core_end_monitor
    import core_mon_pkg::*;
#(
    parameter logic [31:0]      LAST_PC        = 32'h0000_02b4,
    parameter logic [7:0]       DRAIN_CYCLES   = 8'd2,
    parameter logic [CNT_W-1:0] HANG_CYCLES    = 32'd1024,
    parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 32'd45_000_000
) (
    input  logic              clk,
    input  logic              rst,
    core_end_monitor_if.slave mon
);

    mon_state_e       state_r;
    fail_code_e       fail_r;
    logic [7:0]       drain_r;
    logic             done_r;
    logic             pass_r;
    logic [CNT_W-1:0] cycle_cnt_s;
    logic [CNT_W-1:0] retire_cnt_s;
    logic [CNT_W-1:0] hang_cnt_s;
    logic             frozen_s;
    logic             hang_hold_s;
    logic             hang_clr_s;
    logic             last_hit_s;
    logic             timeout_s;
    logic             hang_s;

    assign frozen_s    = is_terminal(state_r);
    assign hang_hold_s = frozen_s || (state_r == DRAIN);
    assign hang_clr_s  = mon.retire_valid || (state_r == IDLE);
    assign last_hit_s  = mon.retire_valid && (mon.retire_pc == LAST_PC);
    assign timeout_s   = (cycle_cnt_s == (TIMEOUT_CYCLES - 32'd1));
    // The retire that would clear the counter this edge also cancels the hang.
    assign hang_s      = !mon.retire_valid && (hang_cnt_s == (HANG_CYCLES - 32'd1));

    sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (1'b1),
        .hold  (frozen_s),
        .count (cycle_cnt_s)
    );

    sat_counter #(.WIDTH(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (mon.retire_valid),
        .hold  (frozen_s),
        .count (retire_cnt_s)
    );

    sat_counter #(.WIDTH(CNT_W)) u_hang_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (hang_clr_s),
        .inc   (1'b1),
        .hold  (hang_hold_s),
        .count (hang_cnt_s)
    );

    // Monitor FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            fail_r  <= FAIL_NONE;
            drain_r <= 8'd0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, RUN: begin
                    if (last_hit_s) begin
                        if (DRAIN_CYCLES == 8'd0) begin
                            state_r <= DONE_PASS;
                            done_r  <= 1'b1;
                            pass_r  <= 1'b1;
                        end else begin
                            state_r <= DRAIN;
                            drain_r <= DRAIN_CYCLES;
                        end
                    end else if (timeout_s) begin
                        state_r <= DONE_FAIL;
                        done_r  <= 1'b1;
                        fail_r  <= FAIL_TIMEOUT;
                    end else if ((state_r == RUN) && hang_s) begin
                        state_r <= DONE_FAIL;
                        done_r  <= 1'b1;
                        fail_r  <= FAIL_HANG;
                    end else if (mon.retire_valid) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= state_r;
                    end
                end
                DRAIN: begin
                    if (drain_r == 8'd1) begin
                        state_r <= DONE_PASS;
                        done_r  <= 1'b1;
                        pass_r  <= 1'b1;
                    end else begin
                        drain_r <= drain_r - 8'd1;
                    end
                end
                DONE_PASS, DONE_FAIL: begin
                    state_r <= state_r;
                end
                default: begin
                    state_r <= IDLE;
                    fail_r  <= FAIL_NONE;
                    done_r  <= 1'b0;
                    pass_r  <= 1'b0;
                end
            endcase
        end
    end

    assign mon.done         = done_r;
    assign mon.pass         = pass_r;
    assign mon.fail_code    = fail_r;
    assign mon.cycle_count  = cycle_cnt_s;
    assign mon.retire_count = retire_cnt_s;

endmodule

// File: tb/tb_core_end_monitor.sv
// Two monitor instances with different parameters share one stimulus stream and
// are compared every cycle against an event-time reference model.
module tb_core_end_monitor;

    localparam logic [31:0] LAST = 32'h0000_02b4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rv;
    logic [31:0] pc;

    int total = 0;
    int bad   = 0;

    // Instance parameters: drain, hang, timeout.
    int p_d [2] = '{2, 0};
    int p_h [2] = '{16, 5};
    int p_t [2] = '{100, 150};

    // Reference model: everything expressed as edge numbers since reset.
    int m_cyc [2];
    int m_rcnt [2];
    int m_last_ret [2];
    int m_lp_edge [2];
    int m_fail [2];
    bit m_started [2];
    bit m_drain [2];
    bit m_done [2];
    bit m_pass [2];

    core_end_monitor_if if_a ();
    core_end_monitor_if if_b ();

    assign if_a.retire_valid = rv;
    assign if_a.retire_pc    = pc;
    assign if_b.retire_valid = rv;
    assign if_b.retire_pc    = pc;

    core_end_monitor #(
        .LAST_PC        (LAST),
        .DRAIN_CYCLES   (8'd2),
        .HANG_CYCLES    (32'd16),
        .TIMEOUT_CYCLES (32'd100)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .mon (if_a.slave)
    );

    core_end_monitor #(
        .LAST_PC        (LAST),
        .DRAIN_CYCLES   (8'd0),
        .HANG_CYCLES    (32'd5),
        .TIMEOUT_CYCLES (32'd150)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .mon (if_b.slave)
    );

    // 100 MHz bench clock.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 0; m_rcnt[i] = 0; m_last_ret[i] = 0; m_lp_edge[i] = 0;
            m_fail[i] = 0; m_started[i] = 1'b0; m_drain[i] = 1'b0;
            m_done[i] = 1'b0; m_pass[i] = 1'b0;
        end
    endfunction

    function automatic void finish_pass(input int i);
        m_done[i] = 1'b1;
        m_pass[i] = 1'b1;
    endfunction

    function automatic void finish_fail(input int i, input int code);
        m_done[i] = 1'b1;
        m_fail[i] = code;
    endfunction

    function automatic void model_step(input int i, input bit v, input logic [31:0] p);
        int e;
        if (m_done[i]) return;
        e = m_cyc[i] + 1;
        m_cyc[i] = e;
        if (v) m_rcnt[i]++;
        if (m_drain[i]) begin
            if (e == m_lp_edge[i] + p_d[i]) finish_pass(i);
            return;
        end
        if (v && p == LAST) begin
            if (p_d[i] == 0) finish_pass(i);
            else begin
                m_drain[i] = 1'b1;
                m_lp_edge[i] = e;
            end
            return;
        end
        if (e == p_t[i]) begin
            finish_fail(i, 2);
            return;
        end
        if (v) begin
            m_started[i] = 1'b1;
            m_last_ret[i] = e;
            return;
        end
        if (m_started[i] && (e - m_last_ret[i] == p_h[i])) finish_fail(i, 1);
    endfunction

    task automatic check_all();
        check_val("a.done",  {31'd0, if_a.done},      {31'd0, m_done[0]});
        check_val("a.pass",  {31'd0, if_a.pass},      {31'd0, m_pass[0]});
        check_val("a.fail",  {30'd0, if_a.fail_code}, m_fail[0]);
        check_val("a.cycle", if_a.cycle_count,        m_cyc[0]);
        check_val("a.rcnt",  if_a.retire_count,       m_rcnt[0]);
        check_val("b.done",  {31'd0, if_b.done},      {31'd0, m_done[1]});
        check_val("b.pass",  {31'd0, if_b.pass},      {31'd0, m_pass[1]});
        check_val("b.fail",  {30'd0, if_b.fail_code}, m_fail[1]);
        check_val("b.cycle", if_b.cycle_count,        m_cyc[1]);
        check_val("b.rcnt",  if_b.retire_count,       m_rcnt[1]);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cyc(input bit v, input logic [31:0] p);
        rv = v;
        pc = p;
        @(posedge clk);
        #1;
        model_step(0, v, p);
        model_step(1, v, p);
        check_all();
        @(negedge clk);
    endtask

    // Asynchronous assert between edges, release on a falling edge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rv = 1'b0;
        pc = 32'd0;
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all();
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_program(input int tail);
        for (int k = 0; k < 10; k++) cyc(1'b1, 32'(k * 4));
        cyc(1'b1, LAST);
        for (int k = 0; k < tail; k++) cyc(1'b0, 32'd0);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] r;
        r = {22'd0, $urandom_range(0, 255), 2'b00};
        if (r == LAST) r = r + 32'd4;
        return r;
    endfunction

    task automatic check_program_result();
        check_val("prog.a.pass",  {31'd0, if_a.pass}, 32'd1);
        check_val("prog.a.rcnt",  if_a.retire_count,  32'd11);
        check_val("prog.a.cycle", if_a.cycle_count,   32'd13);
        check_val("prog.b.cycle", if_b.cycle_count,   32'd11);
        check_val("prog.b.fail",  {30'd0, if_b.fail_code}, 32'd0);
    endtask

    initial begin
        int gap;
        int len;
        rst = 1'b0;
        rv  = 1'b0;
        pc  = 32'd0;
        model_reset();

        // Normal program end.
        do_reset();
        run_program(5);
        check_program_result();

        // Hang after five retires.
        do_reset();
        for (int k = 0; k < 5; k++) cyc(1'b1, 32'(k * 4));
        for (int k = 0; k < 30; k++) cyc(1'b0, 32'd0);
        check_val("hang.a.fail",  {30'd0, if_a.fail_code}, 32'd1);
        check_val("hang.a.cycle", if_a.cycle_count,        32'd21);
        check_val("hang.a.rcnt",  if_a.retire_count,       32'd5);
        check_val("hang.b.cycle", if_b.cycle_count,        32'd10);

        // Timeout under continuous non-final retires.
        do_reset();
        for (int k = 0; k < 105; k++) cyc(1'b1, rand_pc());
        check_val("tmo.a.fail",  {30'd0, if_a.fail_code}, 32'd2);
        check_val("tmo.a.cycle", if_a.cycle_count,        32'd100);

        // Final PC on the timeout edge wins.
        do_reset();
        for (int k = 0; k < 99; k++) cyc(1'b1, rand_pc());
        cyc(1'b1, LAST);
        for (int k = 0; k < 4; k++) cyc(1'b0, 32'd0);
        check_val("race.a.pass", {31'd0, if_a.pass},      32'd1);
        check_val("race.a.fail", {30'd0, if_a.fail_code}, 32'd0);

        // First-ever retire is the final PC.
        do_reset();
        for (int k = 0; k < 3; k++) cyc(1'b0, 32'd0);
        cyc(1'b1, LAST);
        check_val("first.b.done", {31'd0, if_b.done}, 32'd1);
        check_val("first.b.rcnt", if_b.retire_count,  32'd1);
        for (int k = 0; k < 4; k++) cyc(1'b0, 32'd0);
        check_val("first.b.cycle", if_b.cycle_count, 32'd4);

        // Reset in the middle of the drain, then a full replay.
        do_reset();
        for (int k = 0; k < 10; k++) cyc(1'b1, 32'(k * 4));
        cyc(1'b1, LAST);
        cyc(1'b1, 32'd0);
        do_reset();
        run_program(5);
        check_program_result();

        // Random traffic with occasional gaps and final-PC hits.
        for (int r = 0; r < 16; r++) begin
            do_reset();
            gap = 0;
            len = 40 + $urandom_range(0, 100);
            for (int k = 0; k < len; k++) begin
                if (gap == 0 && $urandom_range(0, 29) == 0) gap = $urandom_range(1, 25);
                if (gap > 0) begin
                    gap--;
                    cyc(1'b0, rand_pc());
                end else if ($urandom_range(0, 39) == 0) begin
                    cyc(1'b1, LAST);
                end else begin
                    cyc($urandom_range(0, 3) != 0, rand_pc());
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_end_monitor.md
# core_end_monitor

Synthesizable end-of-test monitor that sits directly downstream of `CoreTop`'s retirement port. It watches the committed-instruction stream and detects retirement of the program's last PC, then waits out a pipeline-drain window. It reports pass, hang or timeout with cycle and retire statistics, replacing the fixed wall-clock `$finish` with a deterministic, status-driven stop that the bench or an FPGA status register can consume.

## Interface
Parameters:
- `LAST_PC`, 32'h0000_02b4: byte address whose retirement marks program end.
- `DRAIN_CYCLES`, 2: cycles to wait after the `LAST_PC` retire before `done`. Range 0–255; 0 means immediate. Use 1 for the two-stage pipe.
- `HANG_CYCLES`, 1024: consecutive cycles without a retire (in RUN) that declare a hang. Must be ≥1.
- `TIMEOUT_CYCLES`, 32'd45_000_000: absolute cycle budget from the first post-reset cycle.

Ports:
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: asynchronous, active-low reset.
- `retire_valid` input 1: one instruction committed this cycle.
- `retire_pc` input 32: PC of the committed instruction; valid only with `retire_valid`.
- `done` output 1: terminal state reached; sticky until reset.
- `pass` output 1: `LAST_PC` reached and drained; meaningful only with `done`.
- `fail_code` output 2: 0 none, 1 hang, 2 timeout, 3 reserved (never driven).
- `cycle_count` output 32: cycles since reset release, saturating at 32'hFFFF_FFFF.
- `retire_count` output 32: retired instructions, saturating.

## Operation
- States: IDLE → RUN → DRAIN → DONE_PASS; IDLE/RUN → DONE_FAIL.
- IDLE: waits for the first `retire_valid`, then goes to RUN. The hang counter does not run in IDLE. The timeout counter does run.
- RUN: on `retire_valid && retire_pc==LAST_PC`:
  - DRAIN_CYCLES==0 → DONE_PASS.
  - Otherwise → DRAIN, loading the drain counter with DRAIN_CYCLES.
  - A first-ever retire at `LAST_PC` in IDLE takes the same path directly.
- Hang counter: clears on every `retire_valid` and increments otherwise. Reaching HANG_CYCLES in RUN → DONE_FAIL, `fail_code`=1.
- Timeout: `cycle_count`==TIMEOUT_CYCLES-1 while in IDLE/RUN → DONE_FAIL, `fail_code`=2.
- DRAIN: decrements each cycle; at 1 → DONE_PASS. Hang and timeout are ignored in DRAIN. Retires still count, but `LAST_PC` is not re-detected.
- DONE_*: terminal. All counters freeze, and later retires are ignored until reset.
- Priority in one cycle: `LAST_PC` detect > timeout > hang.
- `retire_count` increments on `retire_valid` in IDLE/RUN/DRAIN.
- Counters saturate and never wrap.

## Timing
- Reset (async assert, sync release) sets outputs: `done`=0, `pass`=0, `fail_code`=0, `cycle_count`=0, `retire_count`=0, state IDLE.
- All outputs are registered; no combinational input→output path.
- If the `LAST_PC` retire is sampled at edge N, `done`/`pass` rise after edge N+DRAIN_CYCLES (after N if 0).
- `cycle_count` reads k after the k-th rising edge following reset release. It freezes on the edge that enters DONE_*.
- Hang: N = the last retire edge. `done` with `fail_code`=1 rises after edge N+HANG_CYCLES.
- Reset asserted mid-DRAIN or in DONE: immediate return to reset values. No residual state.

## Structure
- Package `core_mon_pkg`:
  - `mon_state_e` (IDLE, RUN, DRAIN, DONE_PASS, DONE_FAIL).
  - `fail_code_e` (FAIL_NONE=0, FAIL_HANG=1, FAIL_TIMEOUT=2).
  - `localparam CNT_W=32`.
- One sub-module: `sat_counter` (parameter width; inputs `clr`, `inc`, `hold`; saturating output). It is instantiated for the cycle, retire and hang counters.
- The drain counter is an 8-bit down-counter inline in the FSM.
- `CoreTop` exposes `retire_valid`/`retire_pc`. The bench instantiates `core_end_monitor` and calls `$finish` on `done`.

## Test plan
- Reset released, 10 retires at PCs 0x0..0x24, then `LAST_PC`=0x2b4, DRAIN_CYCLES=2 → `done`=`pass`=1 exactly 2 edges later; `retire_count`=11; `fail_code`=0.
- Retire stops after 5 instructions, HANG_CYCLES=16 → `done`=1, `pass`=0, `fail_code`=1, 16 edges after the last retire; counters frozen thereafter.
- TIMEOUT_CYCLES=100, continuous retires never at 0x2b4 → `done` after edge 100; `fail_code`=2; `cycle_count`=100.
- `LAST_PC` retire on the same edge as the timeout expiry → `pass`=1, `fail_code`=0.
- DRAIN_CYCLES=0, first retire is 0x2b4 while in IDLE → `done`=`pass`=1 after that edge; `retire_count`=1.
- `rst` pulsed low mid-DRAIN, then a full program replay → all outputs at 0 during reset; the second run passes with fresh counts.
